rx_mac: RTL
===========

RX_MAC -- requirements
Module: rx_mac

Interface
REQ-001 Parameter XGMII_DATA_WIDTH, default 32, XGMII data width; only 32 is supported.
REQ-002 Parameter XGMII_CTRL_WIDTH, default 4, XGMII control width (one bit per byte lane).
REQ-003 Parameter MIN_FRAME_BYTES, default 64, minimum legal frame length (DA through FCS).
REQ-004 Parameter MAX_FRAME_BYTES, default 1518, maximum legal frame length (DA through FCS).
REQ-005 i_clk  in  1  single clock; all logic on rising edge.
REQ-006 i_reset  in  1  reset, synchronous, active-high.
REQ-007 i_xgmii_rxd  in  32  XGMII receive data; lane 0 = bits 7:0 = first byte on the wire.
REQ-008 i_xgmii_ctrl  in  4  XGMII control; bit n set = lane n carries a control character.
REQ-009 i_xgmii_valid  in  1  word qualifier; words with valid low are ignored.
REQ-010 m_axis_tdata  out  32  frame bytes; lane 0 = earliest byte.
REQ-011 m_axis_tkeep  out  4  byte enables, contiguous from lane 0.
REQ-012 m_axis_tvalid  out  1  beat valid; no tready, so the sink shall accept every beat.
REQ-013 m_axis_tlast  out  1  last beat of a frame.
REQ-014 m_axis_tuser  out  1  frame error; meaningful only with tlast.

Function
REQ-015 Constants: START 0xFB, TERM 0xFD, ERROR 0xFE, IDLE 0x07, PRE 0x55, SFD 0xD5.
REQ-016 States: IDLE, PREAMBLE, DATA, DROP; words with i_xgmii_valid=0 cause no state, counter or holding-register change.
REQ-017 IDLE -> PREAMBLE when word = {55,55,55,FB} and ctrl = 0001; start in any other lane or form is ignored (stay IDLE).
REQ-018 PREAMBLE -> DATA when the next word = {D5,55,55,55} and ctrl = 0000; otherwise -> IDLE, and no output is produced.
REQ-019 Preamble, SFD and control characters shall never appear on m_axis.
REQ-020 DATA keeps a one-word holding register H plus an H-valid flag; on each data word (ctrl = 0000): if H is valid, emit H with keep 1111 and tlast 0; then load H with the word.
REQ-021 TERM in lane 0: emit H with keep 1111, tlast 1, then -> IDLE.
REQ-022 TERM in lane k (1..3), with lanes below k ctrl=0: emit H (tlast 0) if valid; load H with lanes 0..k-1, keep = (1<<k)-1, mark pending-last; next cycle emit H with tlast 1, then -> IDLE.
REQ-023 Pending-last emission shall complete even if i_xgmii_valid is low that cycle.
REQ-024 TERM with zero data bytes since SFD: emit one beat, keep 0000, tlast 1, tuser 1.
REQ-025 Byte counter: 11 bits, cleared on SFD, incremented by the bytes accepted per word; saturates at 2047.
REQ-026 tuser=1 on the tlast beat if: total bytes < MIN_FRAME_BYTES; or any ERROR character was seen in the frame; or any ctrl bit was set in a lane other than a TERM lane.
REQ-027 Frame errors do not end the frame; reception continues to TERM.
REQ-028 Count exceeding MAX_FRAME_BYTES: emit H (if valid, else keep 0000) with tlast 1, tuser 1, then -> DROP.
REQ-029 DROP: discard words; -> IDLE on any word containing TERM or an all-IDLE word.
REQ-030 START seen in DATA (any lane): end the current frame as REQ-028 (tlast 1, tuser 1); -> IDLE without restarting.
REQ-031 FCS bytes are passed through unchecked and counted toward length.
REQ-032 Latency: a data word appears on m_axis exactly 1 valid-word later; outputs are registered.
REQ-033 tvalid is asserted for one cycle per beat; tdata in lanes with keep=0 is 0x00.

Reset
REQ-034 While i_reset=1 at a clock edge: state IDLE; H, pending-last, counter and error flags cleared; tvalid, tlast, tuser = 0; tkeep = 0000; tdata = 0.
REQ-035 Reset mid-frame: the partial frame is discarded with no tlast; the first frame after reset requires a fresh START.

Verification
REQ-036 Send START, SFD, 16 data words, TERM in lane 0 -> 16 beats, keep 1111, last beat tlast 1, tuser 0.
REQ-037 Send 65-byte frame (TERM in lane 1) -> 16 full beats, then a final beat with keep 0001, tlast 1, tuser 0.
REQ-038 Send 40-byte frame -> 10 beats, tlast 1 on the 10th, tuser 1 (runt).
REQ-039 Send a bad SFD word {D4,55,55,55} -> no m_axis activity; the next good frame is received normally.
REQ-040 Send 1600-byte frame -> tlast 1 with tuser 1 at the beat carrying byte 1519; no further beats until the next START.
REQ-041 Assert i_reset for 1 cycle mid-frame, then send a 64-byte frame -> no tlast for the aborted frame; 16 beats for the new frame, tuser 0.

Source files
------------

// File: rtl/rx_mac.sv
// XGMII (32-bit) receive MAC: strips preamble/SFD and delivers frame bytes on an
// AXI-Stream master with no backpressure. A one-word holding register lets tlast ride the final beat.
module rx_mac #(
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int XGMII_CTRL_WIDTH = 4,
  parameter int MIN_FRAME_BYTES  = 64,
  parameter int MAX_FRAME_BYTES  = 1518
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [XGMII_DATA_WIDTH-1:0] i_xgmii_rxd,
  input  logic [XGMII_CTRL_WIDTH-1:0] i_xgmii_ctrl,
  input  logic                        i_xgmii_valid,
  output logic [XGMII_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [XGMII_CTRL_WIDTH-1:0] m_axis_tkeep,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser
);

  localparam logic [7:0] START_CH = 8'hFB;
  localparam logic [7:0] TERM_CH  = 8'hFD;
  localparam logic [7:0] IDLE_CH  = 8'h07;

  localparam logic [XGMII_DATA_WIDTH-1:0] START_WORD = 32'h5555_55FB;
  localparam logic [XGMII_DATA_WIDTH-1:0] SFD_WORD   = 32'hD555_5555;
  localparam logic [XGMII_DATA_WIDTH-1:0] IDLE_WORD  = 32'h0707_0707;

  localparam logic [10:0] MIN_B = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_B = 11'(MAX_FRAME_BYTES);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREAMBLE = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_DROP     = 2'd3;

  logic [1:0]                  state_q, state_d;
  logic [XGMII_DATA_WIDTH-1:0] h_data_q, h_data_d;
  logic [XGMII_CTRL_WIDTH-1:0] h_keep_q, h_keep_d;
  logic                        h_valid_q, h_valid_d;
  logic                        pend_q, pend_d;
  logic [10:0]                 cnt_q, cnt_d;
  logic                        err_q, err_d;

  logic [XGMII_DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [XGMII_CTRL_WIDTH-1:0] out_keep_q, out_keep_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic                        out_user_q, out_user_d;

  logic [3:0]                  term_lane, start_lane;
  logic                        term_found;
  logic [1:0]                  term_idx;
  logic [3:0]                  lane_mask;
  logic [XGMII_DATA_WIDTH-1:0] byte_mask;
  logic                        all_idle;
  logic                        frame_bad;
  logic [XGMII_DATA_WIDTH-1:0] h_data_v;
  logic [XGMII_CTRL_WIDTH-1:0] h_keep_v;

  function automatic logic [10:0] sat_add(input logic [10:0] c, input logic [2:0] n);
    logic [11:0] s;
    s = {1'b0, c} + {9'b0, n};
    return s[11] ? 11'h7FF : s[10:0];
  endfunction

  always_comb begin
    term_found = 1'b0;
    term_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      term_lane[i]  = i_xgmii_ctrl[i] && (i_xgmii_rxd[8*i +: 8] == TERM_CH);
      start_lane[i] = i_xgmii_ctrl[i] && (i_xgmii_rxd[8*i +: 8] == START_CH);
    end
    // Descending scan leaves the lowest TERM lane selected.
    for (int i = 3; i >= 0; i--) begin
      if (term_lane[i]) begin
        term_found = 1'b1;
        term_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    unique case (term_idx)
      2'd1:    lane_mask = 4'b0001;
      2'd2:    lane_mask = 4'b0011;
      2'd3:    lane_mask = 4'b0111;
      default: lane_mask = 4'b0000;
    endcase
    byte_mask = {{8{lane_mask[3]}}, {8{lane_mask[2]}}, {8{lane_mask[1]}}, {8{lane_mask[0]}}};
  end

  assign all_idle  = (i_xgmii_ctrl == 4'hF) && (i_xgmii_rxd == IDLE_WORD) && (IDLE_CH == 8'h07);
  assign frame_bad = err_q || (cnt_q < MIN_B) || (cnt_q > MAX_B);
  assign h_data_v  = h_valid_q ? h_data_q : '0;
  assign h_keep_v  = h_valid_q ? h_keep_q : '0;

  always_comb begin
    state_d     = state_q;
    h_data_d    = h_data_q;
    h_keep_d    = h_keep_q;
    h_valid_d   = h_valid_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_data_d  = '0;
    out_keep_d  = '0;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_user_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_xgmii_valid && i_xgmii_rxd == START_WORD && i_xgmii_ctrl == 4'b0001) begin
          state_d = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (i_xgmii_valid) begin
          if (i_xgmii_rxd == SFD_WORD && i_xgmii_ctrl == 4'b0000) begin
            state_d   = S_DATA;
            cnt_d     = '0;
            err_d     = 1'b0;
            h_valid_d = 1'b0;
            pend_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (pend_q) begin
          // Partial final word goes out regardless of the input qualifier.
          out_valid_d = 1'b1;
          out_data_d  = h_data_v;
          out_keep_d  = h_keep_v;
          out_last_d  = 1'b1;
          out_user_d  = frame_bad;
          h_valid_d   = 1'b0;
          pend_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (i_xgmii_valid) begin
          if (cnt_q > MAX_B || (|start_lane)) begin
            out_valid_d = 1'b1;
            out_data_d  = h_data_v;
            out_keep_d  = h_keep_v;
            out_last_d  = 1'b1;
            out_user_d  = 1'b1;
            h_valid_d   = 1'b0;
            state_d     = (term_found || (|start_lane)) ? S_IDLE : S_DROP;
          end else if (term_found && term_idx == 2'd0) begin
            out_valid_d = 1'b1;
            out_data_d  = h_data_v;
            out_keep_d  = h_keep_v;
            out_last_d  = 1'b1;
            out_user_d  = h_valid_q ? frame_bad : 1'b1;
            h_valid_d   = 1'b0;
            state_d     = S_IDLE;
          end else begin
            if (h_valid_q) begin
              out_valid_d = 1'b1;
              out_data_d  = h_data_q;
              out_keep_d  = h_keep_q;
            end
            h_valid_d = 1'b1;
            if (term_found) begin
              h_data_d = i_xgmii_rxd & byte_mask;
              h_keep_d = lane_mask;
              pend_d   = 1'b1;
              cnt_d    = sat_add(cnt_q, {1'b0, term_idx});
              err_d    = err_q | (|(i_xgmii_ctrl & lane_mask));
            end else begin
              h_data_d = i_xgmii_rxd;
              h_keep_d = 4'hF;
              cnt_d    = sat_add(cnt_q, 3'd4);
              err_d    = err_q | (|i_xgmii_ctrl);
            end
          end
        end
      end
      S_DROP: begin
        if (i_xgmii_valid && (term_found || all_idle)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      h_data_q    <= '0;
      h_keep_q    <= '0;
      h_valid_q   <= 1'b0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_data_q    <= h_data_d;
      h_keep_q    <= h_keep_d;
      h_valid_q   <= h_valid_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_user_q  <= out_user_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;

endmodule
